// File: rtl/accelerator_loader_if.sv
// Word stream from the host into accelerator_loader: valid/ready handshake
// with a 32-bit data word.
interface accelerator_loader_if;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] s_data;

    modport master (output s_valid, output s_data, input  s_ready);
    modport slave  (input  s_valid, input  s_data, output s_ready);
endinterface

// File: rtl/accelerator_loader.sv
// Streams header + (InexRecur, state) entry pairs into both accelerator
// register files, then raises is_start once the final write has landed.
module accelerator_loader #(
    parameter int ADDR_W      = 12,
    parameter int IR_W        = 32,
    parameter int ST_W        = 18,
    parameter int MAX_ENTRIES = 4096
) (
    input  logic                 clk,
    input  logic                 rst_n,
    accelerator_loader_if.slave  s_if,
    input  logic                 clear_i,
    output logic                 ran_we_InexRecur,
    output logic [ADDR_W-1:0]    ran_w_addr_InexRecur,
    output logic [IR_W-1:0]      ran_w_data_InexRecur,
    output logic                 ran_we_state_external,
    output logic [ADDR_W-1:0]    ran_w_addr_state_external,
    output logic [ST_W-1:0]      ran_w_data_state_external,
    output logic                 is_start,
    output logic                 busy_o,
    output logic                 err_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD_IR, S_LOAD_ST, S_RUN, S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [12:0]        r_count;
    logic [ADDR_W-1:0]  r_idx;
    logic [IR_W-1:0]    r_hold;
    logic               r_we;
    logic [ADDR_W-1:0]  r_addr;
    logic [IR_W-1:0]    r_ir_data;
    logic [ST_W-1:0]    r_st_data;
    logic               r_is_start;
    logic               r_busy;
    logic               r_err;

    logic               w_hs;
    logic               w_take;
    logic               w_last;
    logic [12:0]        w_hdr_count;
    logic               w_hdr_bad;

    assign w_hs        = s_if.s_valid && s_if.s_ready;
    // A clear in a load state swallows the word offered in the same cycle.
    assign w_take      = w_hs && ((r_state == S_IDLE) || !clear_i);
    assign w_hdr_count = s_if.s_data[12:0];
    assign w_hdr_bad   = (w_hdr_count == 13'd0) ||
                         (32'(w_hdr_count) > 32'(MAX_ENTRIES));
    assign w_last      = (32'(r_idx) == (32'(r_count) - 32'd1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // NOTE: w_next is defaulted before the case so no path infers a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (w_take) w_next = w_hdr_bad ? S_ERR : S_LOAD_IR;
            S_LOAD_IR: if (clear_i) w_next = S_IDLE;
                       else if (w_take) w_next = S_LOAD_ST;
            S_LOAD_ST: if (clear_i) w_next = S_IDLE;
                       else if (w_take) w_next = w_last ? S_RUN : S_LOAD_IR;
            S_RUN:     if (clear_i) w_next = S_IDLE;
            S_ERR:     if (clear_i) w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    always_comb begin
        s_if.s_ready = (r_state == S_IDLE) || (r_state == S_LOAD_IR) ||
                       (r_state == S_LOAD_ST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count   <= '0;
            r_idx     <= '0;
            r_hold    <= '0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_ir_data <= '0;
            r_st_data <= '0;
        end else begin
            r_we <= 1'b0;
            if (w_take) begin
                case (r_state)
                    S_IDLE: begin
                        r_count <= w_hdr_count;
                        r_idx   <= '0;
                    end
                    S_LOAD_IR: r_hold <= s_if.s_data[IR_W-1:0];
                    S_LOAD_ST: begin
                        r_we      <= 1'b1;
                        r_addr    <= r_idx;
                        r_ir_data <= r_hold;
                        r_st_data <= s_if.s_data[ST_W-1:0];
                        if (!w_last) r_idx <= r_idx + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // is_start waits for a full cycle in RUN so it never overlaps the last write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_is_start <= 1'b0;
            r_busy     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_is_start <= (r_state == S_RUN) && (w_next == S_RUN);
            r_busy     <= (w_next == S_LOAD_IR) || (w_next == S_LOAD_ST);
            r_err      <= (w_next == S_ERR);
        end
    end

    assign ran_we_InexRecur          = r_we;
    assign ran_w_addr_InexRecur      = r_addr;
    assign ran_w_data_InexRecur      = r_ir_data;
    assign ran_we_state_external     = r_we;
    assign ran_w_addr_state_external = r_addr;
    assign ran_w_data_state_external = r_st_data;
    assign is_start                  = r_is_start;
    assign busy_o                    = r_busy;
    assign err_o                     = r_err;

endmodule
